// File: rtl/rab_wch_pkg.sv
// Shared types for the RAB W-channel sender: FSM states, the per-burst
// routing decision carried through the decision queue, and the port limit.
package rab_wch_pkg;

   localparam int MAX_PORTS  = 8;
   localparam int DEC_PORT_W = $clog2(MAX_PORTS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FWD   = 2'd1,
      DRAIN = 2'd2
   } wch_state_t;

   typedef struct packed {
      logic                  drop;
      logic [DEC_PORT_W-1:0] port;
      logic [7:0]            len;
   } wch_dec_t;

   // An out-of-range port has no master behind it, so it is drained.
   function automatic logic dec_is_drop(input wch_dec_t dec, input int n_ports);
      return dec.drop || (int'(dec.port) >= n_ports);
   endfunction

endpackage

// File: rtl/axi_buffer_rab.sv
// Registered FIFO for routing decisions. Exposes the head and the entry
// behind it; a pop on a full queue frees the slot for a same-cycle push.
module axi_buffer_rab #(
   parameter int DATA_WIDTH   = 8,
   parameter int BUFFER_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  valid_in,
   output logic                  ready_out,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   output logic [DATA_WIDTH-1:0] data_next,
   output logic                  valid_next,
   input  logic                  ready_in
);

   localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
   localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFFER_DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUFFER_DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_nxt;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  push, pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign valid_out  = (cnt_q != '0);
   assign valid_next = (cnt_q > CNT_W'(1));
   assign rd_ptr_nxt = ptr_inc(rd_ptr_q);
   assign data_out   = mem_q[rd_ptr_q];
   assign data_next  = mem_q[rd_ptr_nxt];

   always_comb begin
      pop       = valid_out & ready_in;
      ready_out = (cnt_q != FULL_CNT) | pop;
      push      = valid_in & ready_out;
      wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d  = pop ? rd_ptr_nxt : rd_ptr_q;
      cnt_d     = cnt_q;
      if (push && !pop)
         cnt_d = cnt_q + CNT_W'(1);
      else if (pop && !push)
         cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < BUFFER_DEPTH; i++)
            mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         if (push)
            mem_q[wr_ptr_q] <= data_in;
      end
   end

endmodule

// File: rtl/axi4_wch_sender_mp.sv
// W-channel sender: routes each queued burst to one master port or drains it.
// Optional beat-count checking is enabled by defining RAB_WCH_BEATCHK_EN.
//
//   state | meaning
//   IDLE  | no decision at the head, slave W stalled
//   FWD   | head burst passes combinationally to master port head.port
//   DRAIN | head burst accepted and discarded
module axi4_wch_sender_mp
   import rab_wch_pkg::*;
#(
   parameter int C_AXI_DATA_WIDTH = 64,
   parameter int C_AXI_USER_WIDTH = 2,
   parameter int N_PORTS          = 2,
   parameter int DEC_FIFO_DEPTH   = 8,
   localparam int PORT_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
   localparam int STRB_W = C_AXI_DATA_WIDTH / 8
) (
   input  logic                                  axi4_aclk,
   input  logic                                  axi4_arstn,
   input  logic                                  dec_valid,
   output logic                                  dec_ready,
   input  logic                                  dec_drop,
   input  logic [PORT_W-1:0]                     dec_port,
   input  logic [7:0]                            dec_len,
   output logic                                  stall_aw,
   input  logic [C_AXI_DATA_WIDTH-1:0]           s_axi4_wdata,
   input  logic [STRB_W-1:0]                     s_axi4_wstrb,
   input  logic [C_AXI_USER_WIDTH-1:0]           s_axi4_wuser,
   input  logic                                  s_axi4_wlast,
   input  logic                                  s_axi4_wvalid,
   output logic                                  s_axi4_wready,
   output logic [N_PORTS*C_AXI_DATA_WIDTH-1:0]   m_axi4_wdata,
   output logic [N_PORTS*STRB_W-1:0]             m_axi4_wstrb,
   output logic [N_PORTS*C_AXI_USER_WIDTH-1:0]   m_axi4_wuser,
   output logic [N_PORTS-1:0]                    m_axi4_wlast,
   output logic [N_PORTS-1:0]                    m_axi4_wvalid,
   input  logic [N_PORTS-1:0]                    m_axi4_wready,
   output logic                                  wlast_done,
   output logic                                  wlast_done_drop,
   output logic                                  len_err
);

   localparam int DEC_W = $bits(wch_dec_t);

   wch_state_t       state_q, state_d;
   wch_dec_t         dec_in, head, nxt;
   logic [DEC_W-1:0] fifo_dout, fifo_dnxt;
   logic             head_valid, nxt_valid;
   logic             pop;
   logic             beat_acc, burst_end, wlast_gen;
   logic [7:0]       dec_len_st;
   logic             wlast_done_q, wlast_done_d;
   logic             wlast_done_drop_q, wlast_done_drop_d;
   logic             unused_ok;

   always_comb begin
      dec_in      = '0;
      dec_in.drop = dec_drop;
      dec_in.port = DEC_PORT_W'(dec_port);
      dec_in.len  = dec_len_st;
   end

   axi_buffer_rab #(
      .DATA_WIDTH   (DEC_W),
      .BUFFER_DEPTH (DEC_FIFO_DEPTH)
   ) u_dec_fifo (
      .clk        (axi4_aclk),
      .rstn       (axi4_arstn),
      .data_in    (dec_in),
      .valid_in   (dec_valid),
      .ready_out  (dec_ready),
      .data_out   (fifo_dout),
      .valid_out  (head_valid),
      .data_next  (fifo_dnxt),
      .valid_next (nxt_valid),
      .ready_in   (pop)
   );

   assign head     = wch_dec_t'(fifo_dout);
   assign nxt      = wch_dec_t'(fifo_dnxt);
   assign stall_aw = ~dec_ready;
   assign beat_acc = s_axi4_wvalid & s_axi4_wready;

   // W datapath mux: only the selected port sees traffic, the rest stay at 0.
   always_comb begin
      s_axi4_wready = 1'b0;
      m_axi4_wdata  = '0;
      m_axi4_wstrb  = '0;
      m_axi4_wuser  = '0;
      m_axi4_wlast  = '0;
      m_axi4_wvalid = '0;
      if (state_q == FWD) begin
         for (int i = 0; i < N_PORTS; i++) begin
            if (head.port == DEC_PORT_W'(i)) begin
               s_axi4_wready = m_axi4_wready[i];
               m_axi4_wvalid[i] = s_axi4_wvalid;
               m_axi4_wlast[i]  = wlast_gen;
               m_axi4_wdata[i*C_AXI_DATA_WIDTH +: C_AXI_DATA_WIDTH] = s_axi4_wdata;
               m_axi4_wstrb[i*STRB_W +: STRB_W] = s_axi4_wstrb;
               m_axi4_wuser[i*C_AXI_USER_WIDTH +: C_AXI_USER_WIDTH] = s_axi4_wuser;
            end
         end
      end else if (state_q == DRAIN) begin
         s_axi4_wready = 1'b1;
      end
   end

   always_comb begin
      state_d           = state_q;
      pop               = 1'b0;
      wlast_done_d      = 1'b0;
      wlast_done_drop_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (head_valid)
               state_d = dec_is_drop(head, N_PORTS) ? DRAIN : FWD;
         end
         FWD, DRAIN: begin
            if (burst_end) begin
               pop               = 1'b1;
               wlast_done_d      = 1'b1;
               wlast_done_drop_d = (state_q == DRAIN);
               // Chain straight into the next queued burst to avoid a bubble.
               if (nxt_valid)
                  state_d = dec_is_drop(nxt, N_PORTS) ? DRAIN : FWD;
               else
                  state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
      if (!axi4_arstn) begin
         state_q           <= IDLE;
         wlast_done_q      <= 1'b0;
         wlast_done_drop_q <= 1'b0;
      end else begin
         state_q           <= state_d;
         wlast_done_q      <= wlast_done_d;
         wlast_done_drop_q <= wlast_done_drop_d;
      end
   end

   assign wlast_done      = wlast_done_q;
   assign wlast_done_drop = wlast_done_drop_q;

`ifdef RAB_WCH_BEATCHK_EN
   logic [7:0] beat_cnt_q, beat_cnt_d;
   logic       len_err_q, len_err_d;
   logic       cnt_at_len;

   assign cnt_at_len = (beat_cnt_q == head.len);
   assign burst_end  = beat_acc & cnt_at_len;
   assign wlast_gen  = cnt_at_len;
   assign dec_len_st = dec_len;

   always_comb begin
      beat_cnt_d = beat_cnt_q;
      if (burst_end)
         beat_cnt_d = '0;
      else if (beat_acc)
         beat_cnt_d = beat_cnt_q + 8'd1;
      // Sticky: either an early wlast or a missing wlast at the counted end.
      len_err_d = len_err_q | (beat_acc & (s_axi4_wlast ^ cnt_at_len));
   end

   always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
      if (!axi4_arstn) begin
         beat_cnt_q <= '0;
         len_err_q  <= 1'b0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
         len_err_q  <= len_err_d;
      end
   end

   assign len_err   = len_err_q;
   assign unused_ok = ^nxt.len;
`else
   assign burst_end  = beat_acc & s_axi4_wlast;
   assign wlast_gen  = s_axi4_wlast;
   assign dec_len_st = 8'd0;
   assign len_err    = 1'b0;
   assign unused_ok  = ^{nxt.len, head.len, dec_len};
`endif

endmodule

// File: tb/tb_axi4_wch_sender_mp.sv
// Self-checking bench for axi4_wch_sender_mp with three master ports, so that
// port value 3 exercises the out-of-range drain path.
module tb_axi4_wch_sender_mp;

   localparam int DW    = 64;
   localparam int SW    = DW / 8;
   localparam int UW    = 2;
   localparam int NP    = 3;
   localparam int DEPTH = 8;
   localparam int GUARD = 200;

   typedef struct {
      bit drop;
      int port;
      int len;
   } dec_m_t;

   logic              clk;
   logic              rst_n;
   logic              dec_valid, dec_ready, dec_drop, stall_aw;
   logic [1:0]        dec_port;
   logic [7:0]        dec_len;
   logic [DW-1:0]     s_wdata;
   logic [SW-1:0]     s_wstrb;
   logic [UW-1:0]     s_wuser;
   logic              s_wlast, s_wvalid, s_wready;
   logic [NP*DW-1:0]  m_wdata;
   logic [NP*SW-1:0]  m_wstrb;
   logic [NP*UW-1:0]  m_wuser;
   logic [NP-1:0]     m_wlast, m_wvalid, m_wready;
   logic              wlast_done, wlast_done_drop, len_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   int drop_cnt = 0;
   dec_m_t mq[$];

   axi4_wch_sender_mp #(
      .C_AXI_DATA_WIDTH (DW),
      .C_AXI_USER_WIDTH (UW),
      .N_PORTS          (NP),
      .DEC_FIFO_DEPTH   (DEPTH)
   ) dut (
      .axi4_aclk       (clk),
      .axi4_arstn      (rst_n),
      .dec_valid       (dec_valid),
      .dec_ready       (dec_ready),
      .dec_drop        (dec_drop),
      .dec_port        (dec_port),
      .dec_len         (dec_len),
      .stall_aw        (stall_aw),
      .s_axi4_wdata    (s_wdata),
      .s_axi4_wstrb    (s_wstrb),
      .s_axi4_wuser    (s_wuser),
      .s_axi4_wlast    (s_wlast),
      .s_axi4_wvalid   (s_wvalid),
      .s_axi4_wready   (s_wready),
      .m_axi4_wdata    (m_wdata),
      .m_axi4_wstrb    (m_wstrb),
      .m_axi4_wuser    (m_wuser),
      .m_axi4_wlast    (m_wlast),
      .m_axi4_wvalid   (m_wvalid),
      .m_axi4_wready   (m_wready),
      .wlast_done      (wlast_done),
      .wlast_done_drop (wlast_done_drop),
      .len_err         (len_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(negedge clk) begin
      if (wlast_done === 1'b1) begin
         done_cnt++;
         if (wlast_done_drop === 1'b1) drop_cnt++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic bit routed(input dec_m_t d);
      return !d.drop && d.port < NP;
   endfunction

   task automatic push_dec(input bit drop, input int port, input int len, output int cyc_push);
      int guard = 0;
      dec_m_t d;
      @(negedge clk);
      dec_valid = 1'b1;
      dec_drop  = drop;
      dec_port  = 2'(port);
      dec_len   = 8'(len);
      #1;
      while (dec_ready !== 1'b1 && guard < GUARD) begin
         @(negedge clk);
         #1;
         guard++;
      end
      checks++;
      if (guard >= GUARD) begin
         errors++;
         $display("FAIL push_timeout: dec_ready=%b, want 1", dec_ready);
      end
      @(posedge clk);
      #1;
      dec_valid = 1'b0;
      cyc_push = cyc;
      d.drop = drop; d.port = port; d.len = len;
      mq.push_back(d);
   endtask

   // Presents one beat, waits for the handshake and returns what the masters saw.
   task automatic do_beat(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic [UW-1:0] u,
                          input bit last, input bit rand_rdy,
                          output logic [NP-1:0] mv, output logic [NP*DW-1:0] md,
                          output logic [NP*SW-1:0] ms, output logic [NP*UW-1:0] mu,
                          output logic [NP-1:0] ml, output int cyc_acc);
      int guard = 0;
      @(negedge clk);
      s_wvalid = 1'b1; s_wdata = d; s_wstrb = s; s_wuser = u; s_wlast = last;
      if (rand_rdy) m_wready = NP'($urandom);
      #1;
      while (s_wready !== 1'b1 && guard < GUARD) begin
         @(negedge clk);
         if (rand_rdy) m_wready = NP'($urandom);
         #1;
         guard++;
      end
      checks++;
      if (guard >= GUARD) begin
         errors++;
         $display("FAIL beat_timeout: s_axi4_wready=%b, want 1", s_wready);
      end
      mv = m_wvalid; md = m_wdata; ms = m_wstrb; mu = m_wuser; ml = m_wlast;
      cyc_acc = cyc;
      @(posedge clk);
   endtask

   task automatic w_idle();
      @(negedge clk);
      s_wvalid = 1'b0;
      s_wlast  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #3;
      checks++;
      if (dec_ready !== 1'b1 || stall_aw !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready: dec_ready=%b stall_aw=%b, want 1/0", dec_ready, stall_aw);
      end
      checks++;
      if ({s_wready, m_wvalid, m_wlast, wlast_done, wlast_done_drop, len_err} !== '0 ||
          m_wdata !== '0 || m_wstrb !== '0 || m_wuser !== '0) begin
         errors++;
         $display("FAIL reset_outputs: s_wready=%b m_wvalid=%b done=%b len_err=%b, want all 0",
                  s_wready, m_wvalid, wlast_done, len_err);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      s_wvalid = 1'b1;
      #1;
      checks++;
      if (s_wready !== 1'b0) begin
         errors++;
         $display("FAIL idle_stall: s_axi4_wready=%b with empty queue, want 0", s_wready);
      end
      s_wvalid = 1'b0;
   endtask

   task automatic test_fwd();
      logic [NP-1:0] mv, ml;
      logic [NP*DW-1:0] md, exp_md;
      logic [NP*SW-1:0] ms, exp_ms;
      logic [NP*UW-1:0] mu, exp_mu;
      logic [DW-1:0] d;
      logic [SW-1:0] s;
      logic [UW-1:0] u;
      int c, cp;
      m_wready = '1;
      push_dec(1'b0, 1, 3, cp);
      @(negedge clk);
      s_wvalid = 1'b1;
      s_wdata  = {$urandom, $urandom};
      #1;
      checks++;
      if (s_wready !== 1'b0 || m_wvalid !== 3'b000) begin
         errors++;
         $display("FAIL fwd_latency: s_wready=%b m_wvalid=%b one cycle after push, want 0/000",
                  s_wready, m_wvalid);
      end
      @(negedge clk);
      m_wready = 3'b101;
      #1;
      checks++;
      if (s_wready !== 1'b0 || m_wvalid !== 3'b010) begin
         errors++;
         $display("FAIL fwd_backpressure: s_wready=%b m_wvalid=%b, want 0/010", s_wready, m_wvalid);
      end
      m_wready = '1;
      for (int i = 0; i < 4; i++) begin
         d = {$urandom, $urandom}; s = SW'($urandom); u = UW'($urandom);
         do_beat(d, s, u, i == 3, 1'b0, mv, md, ms, mu, ml, c);
         exp_md = '0; exp_md[DW +: DW] = d;
         exp_ms = '0; exp_ms[SW +: SW] = s;
         exp_mu = '0; exp_mu[UW +: UW] = u;
         checks++;
         if (mv !== 3'b010) begin
            errors++;
            $display("FAIL fwd_wvalid beat %0d: got %b, want 010", i, mv);
         end
         checks++;
         if (md !== exp_md || ms !== exp_ms || mu !== exp_mu) begin
            errors++;
            $display("FAIL fwd_data beat %0d: got %h/%h/%h, want %h/%h/%h", i, md, ms, mu, exp_md, exp_ms, exp_mu);
         end
         checks++;
         if (ml !== ((i == 3) ? 3'b010 : 3'b000)) begin
            errors++;
            $display("FAIL fwd_wlast beat %0d: got %b", i, ml);
         end
         checks++;
         if (wlast_done !== 1'b0) begin
            errors++;
            $display("FAIL fwd_early_done beat %0d: wlast_done=%b, want 0", i, wlast_done);
         end
      end
      void'(mq.pop_front());
      w_idle();
      #1;
      checks++;
      if (wlast_done !== 1'b1 || wlast_done_drop !== 1'b0) begin
         errors++;
         $display("FAIL fwd_done: done=%b drop=%b, want 1/0", wlast_done, wlast_done_drop);
      end
      @(negedge clk);
      #1;
      checks++;
      if (wlast_done !== 1'b0) begin
         errors++;
         $display("FAIL fwd_done_pulse: wlast_done=%b two cycles after last beat, want 0", wlast_done);
      end
   endtask

   task automatic test_drain(input int port, input int len, input bit drop, input string tag);
      logic [NP-1:0] mv, ml;
      logic [NP*DW-1:0] md;
      logic [NP*SW-1:0] ms;
      logic [NP*UW-1:0] mu;
      int c, cp;
      m_wready = '0;
      push_dec(drop, port, len, cp);
      for (int i = 0; i <= len; i++) begin
         do_beat({$urandom, $urandom}, SW'($urandom), UW'($urandom), i == len, 1'b0, mv, md, ms, mu, ml, c);
         checks++;
         if (c !== cp + 1 + i) begin
            errors++;
            $display("FAIL %s_accept_cycle beat %0d: got %0d, want %0d", tag, i, c, cp + 1 + i);
         end
         checks++;
         if (mv !== '0 || md !== '0 || ml !== '0) begin
            errors++;
            $display("FAIL %s_no_master beat %0d: m_wvalid=%b m_wlast=%b, want 0", tag, i, mv, ml);
         end
      end
      void'(mq.pop_front());
      w_idle();
      #1;
      checks++;
      if (wlast_done !== 1'b1 || wlast_done_drop !== 1'b1) begin
         errors++;
         $display("FAIL %s_done: done=%b drop=%b, want 1/1", tag, wlast_done, wlast_done_drop);
      end
      m_wready = '1;
   endtask

   task automatic test_full();
      logic [NP-1:0] mv, ml;
      logic [NP*DW-1:0] md;
      logic [NP*SW-1:0] ms;
      logic [NP*UW-1:0] mu;
      int c, cp, d0, p0;
      dec_m_t d;
      d0 = done_cnt; p0 = drop_cnt;
      for (int i = 0; i < DEPTH; i++) push_dec(1'b1, $urandom_range(0, 3), 0, cp);
      @(negedge clk);
      #1;
      checks++;
      if (dec_ready !== 1'b0 || stall_aw !== 1'b1) begin
         errors++;
         $display("FAIL full_stall: dec_ready=%b stall_aw=%b, want 0/1", dec_ready, stall_aw);
      end
      // Push while the head burst's last beat is accepted on a full queue.
      @(negedge clk);
      dec_valid = 1'b1; dec_drop = 1'b1; dec_port = 2'd0; dec_len = 8'd0;
      s_wvalid = 1'b1; s_wlast = 1'b1;
      #1;
      checks++;
      if (dec_ready !== 1'b1 || s_wready !== 1'b1) begin
         errors++;
         $display("FAIL full_push_pop: dec_ready=%b s_wready=%b, want 1/1", dec_ready, s_wready);
      end
      @(posedge clk);
      #1;
      dec_valid = 1'b0; s_wvalid = 1'b0; s_wlast = 1'b0;
      void'(mq.pop_front());
      d.drop = 1'b1; d.port = 0; d.len = 0;
      mq.push_back(d);
      @(negedge clk);
      #1;
      checks++;
      if (dec_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_count_kept: dec_ready=%b after push+pop on full, want 0", dec_ready);
      end
      do_beat({$urandom, $urandom}, '1, '0, 1'b1, 1'b0, mv, md, ms, mu, ml, c);
      void'(mq.pop_front());
      w_idle();
      #1;
      checks++;
      if (dec_ready !== 1'b1 || stall_aw !== 1'b0) begin
         errors++;
         $display("FAIL full_release: dec_ready=%b stall_aw=%b, want 1/0", dec_ready, stall_aw);
      end
      while (mq.size() > 0) begin
         do_beat({$urandom, $urandom}, '1, '0, 1'b1, 1'b0, mv, md, ms, mu, ml, c);
         void'(mq.pop_front());
      end
      w_idle();
      repeat (2) @(negedge clk);
      checks++;
      if (done_cnt - d0 !== DEPTH + 1 || drop_cnt - p0 !== DEPTH + 1) begin
         errors++;
         $display("FAIL full_done_count: done=%0d drop=%0d, want %0d/%0d",
                  done_cnt - d0, drop_cnt - p0, DEPTH + 1, DEPTH + 1);
      end
   endtask

   task automatic test_back_to_back();
      logic [NP-1:0] mv1, mv2, ml1, ml2;
      logic [NP*DW-1:0] md1, md2;
      logic [NP*SW-1:0] ms;
      logic [NP*UW-1:0] mu;
      int c1, c2, cp, d0;
      m_wready = '1;
      d0 = done_cnt;
      push_dec(1'b0, 0, 0, cp);
      push_dec(1'b0, 1, 0, cp);
      do_beat({$urandom, $urandom}, '1, '0, 1'b1, 1'b0, mv1, md1, ms, mu, ml1, c1);
      do_beat({$urandom, $urandom}, '1, '0, 1'b1, 1'b0, mv2, md2, ms, mu, ml2, c2);
      void'(mq.pop_front());
      void'(mq.pop_front());
      w_idle();
      checks++;
      if (c2 !== c1 + 1) begin
         errors++;
         $display("FAIL b2b_bubble: beats accepted at cycles %0d and %0d, want consecutive", c1, c2);
      end
      checks++;
      if (mv1 !== 3'b001 || mv2 !== 3'b010 || ml1 !== 3'b001 || ml2 !== 3'b010) begin
         errors++;
         $display("FAIL b2b_route: wvalid %b/%b wlast %b/%b, want 001/010", mv1, mv2, ml1, ml2);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (done_cnt - d0 !== 2) begin
         errors++;
         $display("FAIL b2b_done_count: got %0d, want 2", done_cnt - d0);
      end
   endtask

   task automatic test_random();
      logic [NP-1:0] mv, ml, exp_mv, exp_ml;
      logic [NP*DW-1:0] md, exp_md;
      logic [NP*SW-1:0] ms;
      logic [NP*UW-1:0] mu;
      logic [DW-1:0] d;
      int c, cp, n, d0, p0, exp_done, exp_drop;
      dec_m_t h;
      d0 = done_cnt; p0 = drop_cnt; exp_done = 0; exp_drop = 0;
      for (int r = 0; r < 6; r++) begin
         n = $urandom_range(1, 5);
         for (int k = 0; k < n; k++)
            push_dec(($urandom % 4) == 0, $urandom_range(0, 3), $urandom_range(0, 3), cp);
         while (mq.size() > 0) begin
            h = mq.pop_front();
            for (int b = 0; b <= h.len; b++) begin
               d = {$urandom, $urandom};
               do_beat(d, SW'($urandom), UW'($urandom), b == h.len, 1'b1, mv, md, ms, mu, ml, c);
               exp_mv = '0; exp_ml = '0; exp_md = '0;
               if (routed(h)) begin
                  exp_mv[h.port] = 1'b1;
                  exp_ml[h.port] = (b == h.len);
                  exp_md[h.port*DW +: DW] = d;
               end
               checks++;
               if (mv !== exp_mv || ml !== exp_ml || md !== exp_md) begin
                  errors++;
                  $display("FAIL rand_beat r%0d port %0d beat %0d: wvalid %b wlast %b, want %b %b",
                           r, h.port, b, mv, ml, exp_mv, exp_ml);
               end
            end
            exp_done++;
            if (!routed(h)) exp_drop++;
         end
         w_idle();
      end
      m_wready = '1;
      repeat (2) @(negedge clk);
      checks++;
      if (done_cnt - d0 !== exp_done || drop_cnt - p0 !== exp_drop) begin
         errors++;
         $display("FAIL rand_done_count: done=%0d drop=%0d, want %0d/%0d",
                  done_cnt - d0, drop_cnt - p0, exp_done, exp_drop);
      end
      checks++;
      if (len_err !== 1'b0) begin
         errors++;
         $display("FAIL rand_len_err: len_err=%b with consistent bursts, want 0", len_err);
      end
   endtask

`ifdef RAB_WCH_BEATCHK_EN
   task automatic test_beatchk();
      logic [NP-1:0] mv, ml;
      logic [NP*DW-1:0] md;
      logic [NP*SW-1:0] ms;
      logic [NP*UW-1:0] mu;
      int c, cp, d0;
      m_wready = '1;
      d0 = done_cnt;
      push_dec(1'b0, 0, 3, cp);
      for (int i = 0; i < 4; i++) begin
         do_beat({$urandom, $urandom}, '1, '0, i == 1, 1'b0, mv, md, ms, mu, ml, c);
         #1;
         checks++;
         if (len_err !== (i >= 1)) begin
            errors++;
            $display("FAIL chk_len_err beat %0d: got %b, want %b", i, len_err, i >= 1);
         end
         checks++;
         if (ml !== ((i == 3) ? 3'b001 : 3'b000)) begin
            errors++;
            $display("FAIL chk_wlast beat %0d: got %b", i, ml);
         end
      end
      void'(mq.pop_front());
      w_idle();
      repeat (2) @(negedge clk);
      checks++;
      if (done_cnt - d0 !== 1) begin
         errors++;
         $display("FAIL chk_done_count: got %0d, want 1", done_cnt - d0);
      end
   endtask
`endif

   task automatic test_reset_mid_burst();
      logic [NP-1:0] mv, ml;
      logic [NP*DW-1:0] md;
      logic [NP*SW-1:0] ms;
      logic [NP*UW-1:0] mu;
      int c, cp, d0;
      m_wready = '1;
      push_dec(1'b0, 1, 3, cp);
      do_beat({$urandom, $urandom}, '1, '0, 1'b0, 1'b0, mv, md, ms, mu, ml, c);
      do_beat({$urandom, $urandom}, '1, '0, 1'b0, 1'b0, mv, md, ms, mu, ml, c);
      d0 = done_cnt;
      @(negedge clk);
      rst_n = 1'b0;
      s_wlast = 1'b1;
      #1;
      checks++;
      if (s_wready !== 1'b0 || m_wvalid !== '0 || m_wdata !== '0 || m_wlast !== '0) begin
         errors++;
         $display("FAIL rst_mid_outputs: s_wready=%b m_wvalid=%b m_wlast=%b, want 0", s_wready, m_wvalid, m_wlast);
      end
      checks++;
      if (dec_ready !== 1'b1 || stall_aw !== 1'b0 || len_err !== 1'b0 || wlast_done !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_status: dec_ready=%b stall_aw=%b len_err=%b done=%b, want 1/0/0/0",
                  dec_ready, stall_aw, len_err, wlast_done);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      mq.delete();
      #1;
      checks++;
      if (s_wready !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_flush: s_wready=%b after reset with wvalid held, want 0", s_wready);
      end
      repeat (2) @(negedge clk);
      s_wvalid = 1'b0; s_wlast = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (done_cnt !== d0) begin
         errors++;
         $display("FAIL rst_mid_no_done: %0d pulses after reset, want 0", done_cnt - d0);
      end
   endtask

   initial begin
      dec_valid = 1'b0; dec_drop = 1'b0; dec_port = '0; dec_len = '0;
      s_wdata = '0; s_wstrb = '0; s_wuser = '0; s_wlast = 1'b0; s_wvalid = 1'b0;
      m_wready = '0;
      test_reset();
      test_fwd();
      test_drain(0, 1, 1'b1, "drain");
      test_drain(3, 0, 1'b0, "badport");
      test_full();
      test_back_to_back();
      test_random();
`ifdef RAB_WCH_BEATCHK_EN
      test_beatchk();
`endif
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
